rr_mem_arbiter: RTL and testbench
=================================

RR_MEM_ARBITER -- requirements
Module: rr_mem_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8, is the memory address width in bits.
REQ-002 Parameter DATA_WIDTH, default 8, is the memory data width in bits.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  is the reset; it is synchronous and active-high.
REQ-005 data_req  input  4  is the per-channel read request, bit i for channel i, level-held.
REQ-006 data_addr  input  4*ADDRESS_WIDTH  holds the per-channel read address; channel i uses bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-007 data  output  4*DATA_WIDTH  holds the per-channel registered read data, packed like data_addr.
REQ-008 data_rdy  output  4  is the per-channel registered ready flag.
REQ-009 grant  output  4  is the one-hot channel currently owning the memory port; it is zero when no channel owns the port.
REQ-010 busy  output  1  is high whenever the state is not IDLE.
REQ-011 mem_data_addr  output  ADDRESS_WIDTH  is the registered memory read address.
REQ-012 mem_data  input  DATA_WIDTH  is the memory read data; the memory is synchronous with 1-cycle read latency.

Function
REQ-013 Channel i is outstanding when data_req[i]=1 and data_rdy[i]=0.
REQ-014 The state machine SHALL have exactly three states: IDLE, ISSUE and CAPTURE.
REQ-015 In IDLE, if any channel is outstanding, the block selects one channel g by round-robin, searching from (last+1) mod 4 upward with wrap-around; on that edge it sets mem_data_addr to the address of g, sets grant to onehot(g) and moves to ISSUE.
REQ-016 In IDLE with no channel outstanding, the block stays in IDLE, grant=0 and mem_data_addr holds its value.
REQ-017 ISSUE moves to CAPTURE unconditionally after one cycle; mem_data_addr and grant are held.
REQ-018 In CAPTURE with data_req[g]=1, the block loads data[g] from mem_data, sets data_rdy[g]=1, sets last=g, clears grant and moves to IDLE.
REQ-019 Abort: if data_req[g]=0 when sampled in ISSUE or CAPTURE, the block moves to IDLE on that edge with grant=0, leaves data[g] and last unchanged and does not raise data_rdy[g].
REQ-020 The ready flag for channel i clears to 0 on the first edge at which data_req[i]=0; data[i] holds its value.
REQ-021 data_rdy[i] stays at 1 while data_req[i] stays at 1; a new read needs data_req[i] to fall and rise again.
REQ-022 Latency: with the block in IDLE and data_req[i] sampled high at edge N, data_rdy[i] is high after edge N+2.
REQ-023 Throughput: one read completes per 3 cycles; there is no IDLE bubble for the next grant when another channel is already outstanding at the CAPTURE edge, because IDLE arbitrates on the following edge.
REQ-024 data_addr[g] may change after the grant edge without effect; the address is captured at grant.
REQ-025 Requests arriving in ISSUE or CAPTURE wait; there is no pre-emption.
REQ-026 A channel that rises while it is being captured by another grant is considered only in the next IDLE.
REQ-027 The starvation bound is 3 grants: any outstanding channel is granted within 4 arbitration rounds.

Reset
REQ-028 While rst=1, the following outputs reset on the clock edge: state=IDLE, data=0, data_rdy=0, grant=0, mem_data_addr=0.
REQ-029 While rst=1, last resets to 3 so that channel 0 has first priority after reset.
REQ-030 rst asserted mid-transaction (ISSUE or CAPTURE) discards the transaction; no data_rdy is raised, and the block takes the reset values on that edge.
REQ-031 rst has priority over all other state updates.

Verification
REQ-032 Single read: memory[0x12]=0xA5; ch1 requests address 0x12 from IDLE at edge N -> grant=0010 after N; data_rdy[1]=1 and data[1]=0xA5 after N+2; data_req[1] low -> data_rdy[1]=0 after the next edge.
REQ-033 Round-robin: all four channels are held high from reset with memory[addr_i]=0x10+i -> the completion order is 0,1,2,3 with one completion every 3 cycles; each data[i]=0x10+i.
REQ-034 Fairness wrap: ch3 completes; then ch0 and ch3 request together -> ch0 is granted first; ch3 rereads after ch0 completes.
REQ-035 Abort: ch2 is granted and data_req[2] drops during ISSUE -> IDLE on the next edge, data_rdy[2] stays at 0, data[2] is unchanged, and a pending ch0 is granted next.
REQ-036 Reset mid-operation: rst=1 in CAPTURE -> all outputs are 0 after the edge and busy=0; after release with ch3 and ch0 outstanding -> ch0 is granted first.
REQ-037 Address stability: data_addr[1] changes from 0x12 to 0x34 one cycle after the grant -> data[1] returns memory[0x12].

Source files
------------

// File: rtl/rr_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mem_arbiter_if
// Bundles the four client channels and the single memory read port that
// rr_mem_arbiter serves.
//   data_req      : per-channel level-held read request (bit i = channel i)
//   data_addr     : per-channel read address, channel i at [i*AW +: AW]
//   data          : per-channel registered read data, packed like data_addr
//   data_rdy      : per-channel registered ready flag
//   grant         : one-hot owner of the memory port, zero when unowned
//   busy          : arbiter is in the middle of a transaction
//   mem_data_addr : registered memory read address
//   mem_data      : memory read data (synchronous, one cycle of latency)
// The slave modport is the arbiter's view. The master modport is the view of
// everything around it: the clients together with the memory.
// ---------------------------------------------------------------------------
interface rr_mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
);
  logic [3:0]                 data_req;
  logic [4*ADDRESS_WIDTH-1:0] data_addr;
  logic [4*DATA_WIDTH-1:0]    data;
  logic [3:0]                 data_rdy;
  logic [3:0]                 grant;
  logic                       busy;
  logic [ADDRESS_WIDTH-1:0]   mem_data_addr;
  logic [DATA_WIDTH-1:0]      mem_data;

  modport slave (
    input  data_req, data_addr, mem_data,
    output data, data_rdy, grant, busy, mem_data_addr
  );

  modport master (
    output data_req, data_addr, mem_data,
    input  data, data_rdy, grant, busy, mem_data_addr
  );
endinterface

// File: rtl/rr_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mem_arbiter
// Shares one synchronous memory read port between four channels using
// round-robin arbitration. Each read takes three cycles:
//   IDLE    : pick a channel and register its address
//   ISSUE   : the memory samples the address
//   CAPTURE : latch the memory data for the channel
// Ports:
//   clk  : single clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : rr_mem_arbiter_if.slave, which carries the channel and memory signals
// ---------------------------------------------------------------------------
module rr_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input logic            clk,
  input logic            rst,
  rr_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t                     state_q;
  logic [1:0]                 last_q;
  logic [1:0]                 gntIdx_q;
  logic [3:0]                 grant_q;
  logic [3:0]                 rdy_q;
  logic [3:0]                 rdy_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [4*DATA_WIDTH-1:0]    data_q;

  logic [3:0]                 outstanding_d;
  logic                       pickValid_d;
  logic [1:0]                 pickIdx_d;
  logic [1:0]                 cand_d;

  // Round-robin search. The loop walks the offsets from 4 down to 1, so the
  // smallest offset that is outstanding is assigned last and wins. An offset
  // of 4 wraps back onto the last winner, which therefore has the lowest
  // priority.
  always_comb begin
    outstanding_d = bus.data_req & ~rdy_q;
    pickValid_d   = 1'b0;
    pickIdx_d     = last_q;
    cand_d        = last_q;
    for (int k = 4; k >= 1; k--) begin
      cand_d = last_q + 2'(k);
      if (outstanding_d[cand_d]) begin
        pickValid_d = 1'b1;
        pickIdx_d   = cand_d;
      end
    end
  end

  // A ready flag clears as soon as its request drops. A completed capture
  // sets the flag of the channel that owns the port. The capture only
  // happens while that channel's request is high, so it never conflicts
  // with the clear.
  always_comb begin
    rdy_d = rdy_q & bus.data_req;
    if (state_q == CAPTURE && bus.data_req[gntIdx_q]) begin
      rdy_d[gntIdx_q] = 1'b1;
    end
  end

  // This is the main FSM. Reset takes priority over every other update. If
  // the owner's request drops in ISSUE or CAPTURE, the transaction is
  // abandoned: the FSM returns to IDLE and data and last are left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 2'd3;
      gntIdx_q <= 2'd0;
      grant_q  <= 4'b0000;
      rdy_q    <= 4'b0000;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      rdy_q <= rdy_d;
      case (state_q)
        IDLE: begin
          if (pickValid_d) begin
            addr_q   <= bus.data_addr[32'(pickIdx_d)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            gntIdx_q <= pickIdx_d;
            grant_q  <= 4'b0001 << pickIdx_d;
            state_q  <= ISSUE;
          end else begin
            grant_q <= 4'b0000;
          end
        end
        ISSUE: begin
          if (bus.data_req[gntIdx_q]) begin
            state_q <= CAPTURE;
          end else begin
            grant_q <= 4'b0000;
            state_q <= IDLE;
          end
        end
        CAPTURE: begin
          if (bus.data_req[gntIdx_q]) begin
            data_q[32'(gntIdx_q)*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_data;
            last_q <= gntIdx_q;
          end
          grant_q <= 4'b0000;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= 4'b0000;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.data          = data_q;
  assign bus.data_rdy      = rdy_q;
  assign bus.grant         = grant_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.mem_data_addr = addr_q;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mem_arbiter
// Drives rr_mem_arbiter with directed scenarios and then random traffic.
// The bench also provides the synchronous memory. A transaction-level
// reference model predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_rr_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  rr_mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // This is the memory. It returns the word at the registered address one
  // clock later.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_data_addr];

  int            testsRun = 0;
  int            testsFailed = 0;

  // The reference model tracks the following:
  //   mOwner : channel holding the port, or -1 when the port is unowned
  //   mAge   : cycles elapsed since the grant
  //   mLast  : most recent completed channel
  //   mRdy   : ready flags
  //   mData  : data words per channel
  //   mAddr  : address captured at the grant
  int            mOwner;
  int            mAge;
  int            mLast;
  logic [3:0]    mRdy;
  logic [DW-1:0] mData [4];
  logic [AW-1:0] mAddr;

  // Advance the model by one clock edge, using the inputs as they stand
  // just before that edge.
  task automatic modelEdge();
    logic [3:0] keep;
    if (rst) begin
      mOwner = -1; mAge = 0; mLast = 3; mRdy = 4'b0000; mAddr = '0;
      for (int i = 0; i < 4; i++) mData[i] = '0;
    end else begin
      keep = mRdy & bus.data_req;
      if (mOwner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (mLast + k) % 4;
          if (bus.data_req[c] && !mRdy[c]) begin
            mOwner = c;
            mAge   = 0;
            mAddr  = bus.data_addr[c*AW +: AW];
            break;
          end
        end
      end else if (!bus.data_req[mOwner]) begin
        mOwner = -1;
      end else if (mAge == 0) begin
        mAge = 1;
      end else begin
        mData[mOwner] = mem[mAddr];
        keep[mOwner]  = 1'b1;
        mLast         = mOwner;
        mOwner        = -1;
      end
      mRdy = keep;
    end
  endtask

  // Run one clock edge. Outputs are sampled 1 ns after the edge.
  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the reference model.
  task automatic checkOutput(input string tag);
    logic [3:0]      expGrant;
    logic [4*DW-1:0] expData;
    expGrant = (mOwner < 0) ? 4'b0000 : (4'b0001 << mOwner);
    for (int i = 0; i < 4; i++) expData[i*DW +: DW] = mData[i];
    checkVal({tag, "_grant"}, 64'(bus.grant), 64'(expGrant));
    checkVal({tag, "_busy"}, 64'(bus.busy), 64'(mOwner >= 0));
    checkVal({tag, "_rdy"}, 64'(bus.data_rdy), 64'(mRdy));
    checkVal({tag, "_data"}, 64'(bus.data), 64'(expData));
    if (mOwner >= 0) checkVal({tag, "_maddr"}, 64'(bus.mem_data_addr), 64'(mAddr));
  endtask

  // Run one edge and then check every output against the model.
  task automatic stepCheck(input string tag);
    applyStimulus();
    checkOutput(tag);
  endtask

  initial begin
    int          order [$];
    int          doneCycle [$];
    logic [3:0]  prevRdy;
    logic [3:0]  rose;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h12] = 8'hA5;
    mem[8'h34] = 8'h5A;
    for (int i = 0; i < 4; i++) mem[8'h40 + i] = 8'(8'h10 + i);

    // Reset state.
    rst = 1'b1;
    bus.data_req  = 4'b0000;
    bus.data_addr = '0;
    applyStimulus();
    stepCheck("reset");
    checkVal("reset_grant", 64'(bus.grant), 64'h0);
    checkVal("reset_busy", 64'(bus.busy), 64'h0);
    checkVal("reset_data", 64'(bus.data), 64'h0);
    rst = 1'b0;

    // Single read from channel 1.
    bus.data_addr[1*AW +: AW] = 8'h12;
    bus.data_req = 4'b0010;
    stepCheck("single_n");
    checkVal("single_grant", 64'(bus.grant), 64'b0010);
    checkVal("single_maddr", 64'(bus.mem_data_addr), 64'h12);
    stepCheck("single_n1");
    checkVal("single_rdy_early", 64'(bus.data_rdy[1]), 64'h0);
    stepCheck("single_n2");
    checkVal("single_rdy", 64'(bus.data_rdy[1]), 64'h1);
    checkVal("single_data", 64'(bus.data[1*DW +: DW]), 64'hA5);
    bus.data_req = 4'b0000;
    stepCheck("single_drop");
    checkVal("single_rdy_clear", 64'(bus.data_rdy[1]), 64'h0);
    checkVal("single_data_hold", 64'(bus.data[1*DW +: DW]), 64'hA5);

    // Round robin with all four channels held high from reset.
    rst = 1'b1;
    stepCheck("rr_reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) bus.data_addr[i*AW +: AW] = 8'(8'h40 + i);
    bus.data_req = 4'b1111;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      prevRdy = bus.data_rdy;
      stepCheck("rr");
      rose = bus.data_rdy & ~prevRdy;
      for (int c = 0; c < 4; c++) begin
        if (rose[c]) begin
          order.push_back(c);
          doneCycle.push_back(cyc);
        end
      end
    end
    checkVal("rr_count", 64'(order.size()), 64'd4);
    for (int j = 0; j < order.size(); j++) begin
      checkVal("rr_order", 64'(order[j]), 64'(j));
      checkVal("rr_cycle", 64'(doneCycle[j]), 64'(3 * (j + 1)));
    end
    for (int i = 0; i < 4; i++)
      checkVal("rr_data", 64'(bus.data[i*DW +: DW]), 64'(8'h10 + i));

    // Fairness wrap: channel 3 finished last, so channel 0 goes before
    // channel 3.
    bus.data_req = 4'b0000;
    stepCheck("wrap_idle");
    bus.data_req = 4'b1001;
    stepCheck("wrap_g0");
    checkVal("wrap_first", 64'(bus.grant), 64'b0001);
    stepCheck("wrap_c0a");
    stepCheck("wrap_c0b");
    checkVal("wrap_rdy0", 64'(bus.data_rdy[0]), 64'h1);
    stepCheck("wrap_g3");
    checkVal("wrap_second", 64'(bus.grant), 64'b1000);
    stepCheck("wrap_c3a");
    stepCheck("wrap_c3b");
    checkVal("wrap_rdy3", 64'(bus.data_rdy[3]), 64'h1);

    // Abort: channel 2 drops its request during ISSUE while channel 0 is
    // pending.
    bus.data_req = 4'b0000;
    stepCheck("abort_idle");
    bus.data_addr[2*AW +: AW] = 8'h77;
    bus.data_req = 4'b0100;
    stepCheck("abort_g2");
    checkVal("abort_grant2", 64'(bus.grant), 64'b0100);
    bus.data_req = 4'b0001;
    stepCheck("abort_drop");
    checkVal("abort_grant0", 64'(bus.grant), 64'b0000);
    checkVal("abort_busy", 64'(bus.busy), 64'h0);
    checkVal("abort_rdy2", 64'(bus.data_rdy[2]), 64'h0);
    checkVal("abort_data2", 64'(bus.data[2*DW +: DW]), 64'h12);
    stepCheck("abort_next");
    checkVal("abort_next_grant", 64'(bus.grant), 64'b0001);

    // Reset asserted during CAPTURE.
    stepCheck("rstmid_cap");
    rst = 1'b1;
    stepCheck("rstmid_edge");
    checkVal("rstmid_grant", 64'(bus.grant), 64'h0);
    checkVal("rstmid_rdy", 64'(bus.data_rdy), 64'h0);
    checkVal("rstmid_data", 64'(bus.data), 64'h0);
    checkVal("rstmid_maddr", 64'(bus.mem_data_addr), 64'h0);
    checkVal("rstmid_busy", 64'(bus.busy), 64'h0);
    rst = 1'b0;
    bus.data_req = 4'b1001;
    stepCheck("rstmid_after");
    checkVal("rstmid_first", 64'(bus.grant), 64'b0001);

    // The address is captured at the grant. A later change has no effect.
    rst = 1'b1;
    bus.data_req = 4'b0000;
    stepCheck("addr_reset");
    rst = 1'b0;
    bus.data_addr[1*AW +: AW] = 8'h12;
    bus.data_req = 4'b0010;
    stepCheck("addr_grant");
    bus.data_addr[1*AW +: AW] = 8'h34;
    stepCheck("addr_issue");
    stepCheck("addr_capture");
    checkVal("addr_rdy", 64'(bus.data_rdy[1]), 64'h1);
    checkVal("addr_data", 64'(bus.data[1*DW +: DW]), 64'hA5);

    // Random traffic with occasional resets. Every cycle is checked against
    // the model.
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(3) == 0) bus.data_req[c] = ~bus.data_req[c];
        if ($urandom_range(5) == 0) bus.data_addr[c*AW +: AW] = 8'($urandom);
      end
      rst = ($urandom_range(79) == 0);
      stepCheck("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
